// File: rtl/fp_accum_seq.sv
// fp_accum_seq: streams bf16 elements through the external combinational fp_add stage,
// keeping a running sum, sticky exception flags and an element count per sequence.
module fp_accum_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic [15:0]      add_opA,
  output logic [15:0]      add_opB,
  input  logic [15:0]      add_sum,
  input  logic             add_overflow,
  input  logic             add_underflow,
  input  logic             add_inexact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [2:0]       out_flags,
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic [1:0] {IDLE, WAIT, EXEC, DONE} state_t;
  state_t           r_state, w_next;
  logic [15:0]      r_acc, r_opb;
  logic [2:0]       r_flags;
  logic [CNT_W-1:0] r_count;
  logic             r_last;
  logic             w_accept;
  assign in_ready  = (r_state == IDLE) || (r_state == WAIT);
  assign out_valid = r_state == DONE;
  assign w_accept  = in_valid & in_ready;
  assign add_opA   = r_acc;
  assign add_opB   = r_opb;
  assign out_data  = r_acc;
  assign out_flags = r_flags;
  assign out_count = r_count;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? (in_last ? DONE : WAIT) : IDLE;
      WAIT:    w_next = w_accept ? EXEC : WAIT;
      EXEC:    w_next = r_last ? DONE : WAIT;
      default: w_next = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_opb   <= '0;
      r_flags <= '0;
      r_count <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_accept) begin
          // first element bypasses the adder, which mishandles a zero operand
          r_acc   <= in_data;
          r_count <= {{(CNT_W-1){1'b0}}, 1'b1};
        end
        WAIT: if (w_accept) begin
          r_opb  <= in_data;
          r_last <= in_last;
        end
        EXEC: begin
          r_acc   <= add_sum;
          r_flags <= r_flags | {add_overflow, add_underflow, add_inexact};
          r_count <= (&r_count) ? r_count : r_count + 1'b1;
        end
        default: if (out_ready) begin
          r_acc   <= '0;
          r_opb   <= '0;
          r_flags <= '0;
          r_count <= '0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_accum_seq.sv
// tb_fp_accum_seq: directed checks of fp_accum_seq against a lookup-table stand-in for fp_add.
module tb_fp_accum_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [15:0] add_opA, add_opB, add_sum, out_data;
  logic        add_overflow, add_underflow, add_inexact;
  logic [2:0]  out_flags;
  logic [7:0]  out_count;
  int checks = 0, errors = 0;
  fp_accum_seq #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .add_opA(add_opA), .add_opB(add_opB),
    .add_sum(add_sum), .add_overflow(add_overflow), .add_underflow(add_underflow),
    .add_inexact(add_inexact), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .out_count(out_count)
  );
  always #5 clk = ~clk;
  // hand-computed bf16 sums for the operand pairs the vectors produce
  always_comb begin
    {add_sum, add_overflow, add_underflow, add_inexact} = {16'hFFFF, 3'b000};
    case ({add_opA, add_opB})
      {16'h3F80, 16'h4000}: {add_sum, add_overflow, add_underflow, add_inexact} = {16'h4040, 3'b000};
      {16'h4040, 16'h4040}: {add_sum, add_overflow, add_underflow, add_inexact} = {16'h40C0, 3'b000};
      {16'h7F00, 16'h7F00}: {add_sum, add_overflow, add_underflow, add_inexact} = {16'h7F80, 3'b100};
      {16'h3F80, 16'hBF80}: {add_sum, add_overflow, add_underflow, add_inexact} = {16'h0000, 3'b000};
      {16'h7F80, 16'h3F80}: {add_sum, add_overflow, add_underflow, add_inexact} = {16'h7F80, 3'b001};
      {16'h4000, 16'h0001}: {add_sum, add_overflow, add_underflow, add_inexact} = {16'h4000, 3'b001};
      {16'h3F80, 16'h3F80}: {add_sum, add_overflow, add_underflow, add_inexact} = {16'h4000, 3'b000};
      {16'h0000, 16'h0000}: {add_sum, add_overflow, add_underflow, add_inexact} = {16'h0000, 3'b000};
      default: ;
    endcase
  end
  typedef struct {
    logic [2:0][15:0] d;
    int               n;
    logic [15:0]      sum;
    logic [7:0]       cnt;
    logic [2:0]       fl;
  } vec_t;
  vec_t vecs[6];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic send(input logic [15:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask
  task automatic get_result(input string name, input logic [15:0] sum, input logic [7:0] cnt, input logic [2:0] fl);
    int n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk({name, "_valid"}, 32'(out_valid), 1);
    chk({name, "_data"}, 32'(out_data), 32'(sum));
    chk({name, "_count"}, 32'(out_count), 32'(cnt));
    chk({name, "_flags"}, 32'(out_flags), 32'(fl));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_release"}, {31'd0, out_valid}, 0);
  endtask
  initial begin
    logic [5:0] rdy, ov;
    logic [2:0][15:0] d3;
    logic acc_now;
    int idx;
    vecs[0] = '{{16'h4040, 16'h4000, 16'h3F80}, 3, 16'h40C0, 8'd3, 3'b000};
    vecs[1] = '{{16'h0000, 16'h0000, 16'hBF80}, 1, 16'hBF80, 8'd1, 3'b000};
    vecs[2] = '{{16'h0000, 16'h7F00, 16'h7F00}, 2, 16'h7F80, 8'd2, 3'b100};
    vecs[3] = '{{16'h0000, 16'hBF80, 16'h3F80}, 2, 16'h0000, 8'd2, 3'b000};
    vecs[4] = '{{16'h0000, 16'h0001, 16'h4000}, 2, 16'h4000, 8'd2, 3'b001};
    vecs[5] = '{{16'h3F80, 16'h7F00, 16'h7F00}, 3, 16'h7F80, 8'd3, 3'b101};
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_opA", 32'(add_opA), 0);
    chk("rst_opB", 32'(add_opB), 0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_flags", 32'(out_flags), 0);
    #10 reset = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vecs[i].n; j++) send(vecs[i].d[j], j == vecs[i].n - 1);
      if (vecs[i].n == 1) chk("single_opB", 32'(add_opB), 0);
      get_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cnt, vecs[i].fl);
    end
    // streaming timing with in_valid held high
    d3 = {16'h4040, 16'h4000, 16'h3F80};
    idx = 0;
    in_valid = 1'b1;
    in_data = d3[0];
    in_last = 1'b0;
    for (int e = 0; e < 6; e++) begin
      acc_now = in_valid & in_ready;
      step();
      if (acc_now) begin
        idx++;
        if (idx == 3) in_valid = 1'b0;
        else begin
          in_data = d3[idx];
          in_last = idx == 2;
        end
      end
      rdy[e] = in_ready;
      ov[e] = out_valid;
    end
    chk("stream_in_ready", 32'(rdy), 32'(6'b000101));
    chk("stream_out_valid", 32'(ov), 32'(6'b110000));
    get_result("stream", 16'h40C0, 8'd3, 3'b000);
    // backpressure in DONE with a pending element
    send(16'hBF80, 1'b1);
    in_valid = 1'b1;
    in_data = 16'h3F80;
    in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'(16'hBF80));
      chk("bp_count", 32'(out_count), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle_ready", 32'(in_ready), 1);
    chk("bp_idle_valid", 32'(out_valid), 0);
    step();
    in_valid = 1'b0;
    get_result("bp_pending", 16'h3F80, 8'd1, 3'b000);
    // reset during EXEC
    send(16'h3F80, 1'b0);
    in_valid = 1'b1;
    in_data = 16'h4000;
    in_last = 1'b0;
    step();
    in_valid = 1'b0;
    chk("exec_in_ready", 32'(in_ready), 0);
    chk("exec_opB", 32'(add_opB), 32'(16'h4000));
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_opA", 32'(add_opA), 0);
    chk("mid_rst_opB", 32'(add_opB), 0);
    chk("mid_rst_flags", 32'(out_flags), 0);
    chk("mid_rst_count", 32'(out_count), 0);
    step();
    reset = 1'b0;
    ov = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      ov[c] = out_valid;
    end
    chk("post_rst_no_valid", 32'(ov), 0);
    send(16'h3F80, 1'b0);
    send(16'h3F80, 1'b1);
    get_result("post_rst", 16'h4000, 8'd2, 3'b000);
    // counter saturation
    for (int k = 0; k < 257; k++) send(16'h0000, k == 256);
    get_result("saturate", 16'h0000, 8'd255, 3'b000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
